mul_div_unit: RTL and testbench

- Multi-cycle integer multiply/divide execute unit.
- Sits directly downstream of the register file read ports.
- Takes the two read operands plus a destination register number, iterates one bit per cycle, and returns the result on a write-back port (data, address, load) that drives the register file write port.
- Also holds HI/LO result registers for MFHI/MFLO-style reads.

---
 rtl/mdu_defs.sv | 20 ++
 rtl/mdu_cond_neg.sv | 14 +
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// rtl/mdu_defs.sv - shared op/state encodings and default sizes for the mul/div unit
// Purpose: constants imported by mul_div_unit and mdu_cond_neg.
// Ports:   none (package).
package mdu_defs;

  localparam int MDU_WIDTH  = 16;
  localparam int MDU_ADDR_W = 4;

  // op[1] selects divide, op[0] selects signed; the datapath relies on that split.
  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mdu_cond_neg.sv
// rtl/mdu_cond_neg.sv - conditional two's-complement negate
// Purpose: val_o = neg_i ? -val_i : val_i, used for operand magnitudes and result sign fix-up.
// Ports:   val_i [WIDTH] value in, neg_i negate enable, val_o [WIDTH] value out.
module mdu_cond_neg #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle integer multiply/divide unit with register-file write-back
// Purpose: one-bit-per-cycle shift-add multiply and restoring divide, signed via magnitudes
//          plus sign fix-up; result held in hi/lo and written back through wb_* for one cycle.
// Ports:   clk, nClear (async active-low reset), start/op/opA/opB/dest request inputs,
//          busy, done, hi, lo, wb_data, wb_addr, wb_load, div_zero outputs.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH  = MDU_WIDTH,
  parameter int ADDR_W = MDU_ADDR_W
) (
  input  logic              clk,
  input  logic              nClear,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic [WIDTH-1:0]  wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_load,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic               is_div_q;
  logic [ADDR_W-1:0]  dest_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               res_neg_q;
  logic               rem_neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_zero_q;

  // Operand magnitudes for signed ops; unsigned ops pass straight through.
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign a_neg_in = op[0] & opA[WIDTH-1];
  assign b_neg_in = op[0] & opB[WIDTH-1];

  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_a (.val_i(opA), .neg_i(a_neg_in), .val_o(mag_a));
  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_b (.val_i(opB), .neg_i(b_neg_in), .val_o(mag_b));

  // One iteration step. The accumulator holds {partial product, multiplier} for
  // multiply and {remainder, dividend/quotient} for divide.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_rem_sh;
  logic [WIDTH:0] div_diff;

  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  // The running remainder is below 2*divisor, so WIDTH+1 bits hold the difference sign.
  assign div_diff   = div_rem_sh - {1'b0, b_q};

  always_comb begin
    acc_d = acc_q;
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mdu_cond_neg #(.WIDTH(2*WIDTH)) u_neg_prod (.val_i(acc_q), .neg_i(res_neg_q), .val_o(prod_fix));
  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(res_neg_q), .val_o(quo_fix)
  );
  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rem_neg_q), .val_o(rem_fix)
  );

  logic b_zero;
  assign b_zero = (b_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state_q    <= ST_IDLE;
      is_div_q   <= 1'b0;
      dest_q     <= '0;
      b_q        <= '0;
      a_raw_q    <= '0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_div_q   <= op[1];
            dest_q     <= dest;
            b_q        <= mag_b;
            a_raw_q    <= opA;
            res_neg_q  <= a_neg_in ^ b_neg_in;
            rem_neg_q  <= a_neg_in;
            cnt_q      <= '0;
            acc_q      <= {{WIDTH{1'b0}}, mag_a};
            div_zero_q <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_FIX: begin
          if (is_div_q && b_zero) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            hi_q       <= a_raw_q;
            lo_q       <= '1;
            div_zero_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done     = (state_q == ST_DONE);
  assign wb_load  = done;
  assign wb_data  = done ? lo_q : '0;
  assign wb_addr  = dest_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit
module tb_mul_div_unit;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          nClear;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  opA, opB;
  logic [AW-1:0] dest;
  logic          busy, done, wb_load, div_zero;
  logic [W-1:0]  hi, lo, wb_data;
  logic [AW-1:0] wb_addr;

  mul_div_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .nClear(nClear), .start(start), .op(op), .opA(opA), .opB(opB),
    .dest(dest), .busy(busy), .done(done), .hi(hi), .lo(lo), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_load(wb_load), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [AW-1:0] addr;
    logic          dz;
    int            issue;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua, ub, sa, sbv, p, q, r;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dz = 1'b0;
    e.addr = '0;
    e.issue = 0;
    if (o[1] == 1'b0) begin
      p = o[0] ? sa * sbv : ua * ub;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      if (o[0]) begin q = sa / sbv; r = sa % sbv; end
      else      begin q = ua / ub;  r = ua % ub;  end
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
    end
    return e;
  endfunction

  // Monitor: every completion must match the oldest outstanding request.
  exp_t m_e;
  always @(negedge clk) begin
    if (nClear === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        m_e = sb.pop_front();
        chk("hi", hi, m_e.hi);
        chk("lo", lo, m_e.lo);
        chk("wb_data", wb_data, m_e.lo);
        chk("wb_addr", wb_addr, m_e.addr);
        chk("wb_load", wb_load, 1);
        chk("div_zero", div_zero, m_e.dz);
        chk("busy_at_done", busy, 0);
        chk("latency", cyc - m_e.issue, LAT);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < LAT + 12 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] d, input bit inject);
    exp_t e;
    @(negedge clk);
    op = o; opA = a; opB = b; dest = d; start = 1'b1;
    e = model(o, a, b);
    e.addr = d;
    e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Inputs wander after the start edge; the result must not follow them.
    op = 2'($urandom); opA = W'($urandom); opB = W'($urandom); dest = AW'($urandom);
    chk("busy_after_start", busy, 1);
    chk("dz_cleared_at_start", div_zero, 0);
    if (inject) begin
      repeat (4) @(negedge clk);
      start = 1'b1; op = ~o; opA = a ^ 16'h5A5A; opB = b + 16'd1; dest = d + 4'd1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid_run", busy, 1);
    end
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wb_load"}, wb_load, 0);
    chk({tag, "_div_zero"}, div_zero, 0);
    chk({tag, "_hi"}, hi, 0);
    chk({tag, "_lo"}, lo, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
  endtask

  initial begin
    nClear = 1'b0; start = 1'b0; op = '0; opA = '0; opB = '0; dest = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    nClear = 1'b1;

    run_op(2'b00, 16'h1234, 16'h0010, 4'd5, 1'b0);
    run_op(2'b01, 16'hFFFD, 16'h0007, 4'd1, 1'b0);
    run_op(2'b11, 16'hFFF9, 16'h0002, 4'd2, 1'b0);
    run_op(2'b10, 16'h0064, 16'h0007, 4'd3, 1'b0);
    run_op(2'b10, 16'h00AB, 16'h0000, 4'd4, 1'b0);
    repeat (3) @(negedge clk);
    chk("div_zero_sticky", div_zero, 1);
    run_op(2'b00, 16'h0003, 16'h0005, 4'd0, 1'b0);
    run_op(2'b11, 16'h8000, 16'hFFFF, 4'd6, 1'b0);
    run_op(2'b11, 16'h8123, 16'h0000, 4'd7, 1'b0);
    run_op(2'b01, 16'h8000, 16'h8000, 4'd8, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd9, 1'b0);

    // Start pulse during RUN is ignored.
    run_op(2'b00, 16'h0ABC, 16'h0123, 4'd10, 1'b1);

    // Asynchronous reset 8 cycles into RUN abandons the operation.
    @(negedge clk);
    op = 2'b00; opA = 16'h4321; opB = 16'h0101; dest = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 nClear = 1'b0;
    #1 check_all_zero("midrun_reset");
    repeat (3) @(negedge clk);
    nClear = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    run_op(2'b00, 16'h0003, 16'h0004, 4'd12, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      o = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = W'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, b, AW'($urandom), ($urandom_range(0, 5) == 0));
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
